// File: rtl/riscv_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_hazard_ctrl
// Purpose  : Central pipeline sequencer for the 5-stage RV core. It covers
//            only the hazards that forwarding cannot resolve:
//              - data-memory wait (freeze the pipe, bubble into MEM/WB)
//              - multi-cycle MUL/DIV sequencing (launch, hold, release)
//              - taken branch/jump (squash wrong-path IF/ID and ID/EX)
//              - load-use (one bubble into ID/EX)
//            It also counts stalled cycles with a saturating counter.
// Ports    : clk, rst_n            - clock, synchronous active-low reset
//            rs1/rs2_if2id_ff      - source registers of the ID instruction
//            rd_id2ex_ff           - destination register of the EX instr
//            mem_read_id2ex_ff     - EX instruction is a load
//            is_mdu_id2ex_ff       - EX instruction is MUL/DIV
//            branch_taken_ex       - EX redirects the PC
//            dmem_req_ex2mem_ff    - MEM instruction accesses data memory
//            dmem_ready            - data memory completes this cycle
//            mdu_done              - MDU result valid (pulse)
//            mdu_start             - launch MDU (pulse)
//            stall_*               - hold PC / pipeline registers
//            flush_*               - load a bubble into pipeline registers
//            stall_cnt             - saturating count of stall_pc cycles
// Revision : 1.0 - initial release
// ============================================================================
module riscv_hazard_ctrl #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [RF_ADDR_WIDTH-1:0] rs1_if2id_ff,
  input  logic [RF_ADDR_WIDTH-1:0] rs2_if2id_ff,
  input  logic [RF_ADDR_WIDTH-1:0] rd_id2ex_ff,
  input  logic                     mem_read_id2ex_ff,
  input  logic                     is_mdu_id2ex_ff,
  input  logic                     branch_taken_ex,
  input  logic                     dmem_req_ex2mem_ff,
  input  logic                     dmem_ready,
  input  logic                     mdu_done,
  output logic                     mdu_start,
  output logic                     stall_pc,
  output logic                     stall_if2id,
  output logic                     stall_id2ex,
  output logic                     stall_ex2mem,
  output logic                     flush_if2id,
  output logic                     flush_id2ex,
  output logic                     flush_ex2mem,
  output logic                     flush_mem2wb,
  output logic [CNT_WIDTH-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1
  } state_e;

  state_e               state_q, state_d;
  logic                 done_pending_q, done_pending_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic                 mem_stall;
  logic                 load_use;
  logic                 mdu_release;

  assign mem_stall   = dmem_req_ex2mem_ff & ~dmem_ready;
  assign load_use    = mem_read_id2ex_ff & (rd_id2ex_ff != '0) &
                       ((rd_id2ex_ff == rs1_if2id_ff) | (rd_id2ex_ff == rs2_if2id_ff));
  // A done that was swallowed by a memory freeze is remembered in done_pending
  assign mdu_release = mdu_done | done_pending_q;

  always_comb begin
    state_d        = state_q;
    done_pending_d = done_pending_q;
    mdu_start      = 1'b0;
    stall_pc       = 1'b0;
    stall_if2id    = 1'b0;
    stall_id2ex    = 1'b0;
    stall_ex2mem   = 1'b0;
    flush_if2id    = 1'b0;
    flush_id2ex    = 1'b0;
    flush_ex2mem   = 1'b0;
    flush_mem2wb   = 1'b0;

    if (!rst_n) begin
      // Bubble every stage while in reset so no stale instruction retires
      flush_if2id  = 1'b1;
      flush_id2ex  = 1'b1;
      flush_ex2mem = 1'b1;
      flush_mem2wb = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything up to EX/MEM; MEM/WB gets a bubble each waiting cycle
      stall_pc     = 1'b1;
      stall_if2id  = 1'b1;
      stall_id2ex  = 1'b1;
      stall_ex2mem = 1'b1;
      flush_mem2wb = 1'b1;
      if ((state_q == MDU_BUSY) && mdu_done) begin
        done_pending_d = 1'b1;
      end
    end else if (state_q == MDU_BUSY) begin
      if (mdu_release) begin
        // EX/MEM captures the result, ID/EX advances
        done_pending_d = 1'b0;
        state_d        = RUN;
      end else begin
        stall_pc     = 1'b1;
        stall_if2id  = 1'b1;
        stall_id2ex  = 1'b1;
        flush_ex2mem = 1'b1;
      end
    end else if (is_mdu_id2ex_ff) begin
      // MDU launch takes precedence over branch/load-use in the same cycle
      mdu_start    = 1'b1;
      stall_pc     = 1'b1;
      stall_if2id  = 1'b1;
      stall_id2ex  = 1'b1;
      flush_ex2mem = 1'b1;
      state_d      = MDU_BUSY;
    end else if (branch_taken_ex) begin
      // ID holds a wrong-path instruction, so any load-use on it is moot
      flush_if2id = 1'b1;
      flush_id2ex = 1'b1;
    end else if (load_use) begin
      stall_pc    = 1'b1;
      stall_if2id = 1'b1;
      flush_id2ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      done_pending_q <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      done_pending_q <= done_pending_d;
      if (stall_pc && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire
